id_stage_pipe: RTL and testbench

- Registered, parametrised MIPS instruction-decode stage that replaces the purely combinational decoder.
- Decodes the same 21-instruction set into a one-hot ALU op and resolves operands with EX/MEM forwarding.
- Detects load-use hazards and stalls for them; resolves branches/jumps with a one-instruction delay slot.
- Drives an ID/EX pipeline register with a valid/ready handshake; sits between IF (pc/inst register) and EX.

---
 rtl/id_stage_pipe_pkg.sv | 104 ++++++++++
 rtl/id_fwd_unit.sv | 54 +++++
 rtl/id_stage_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - opcode/func encodings, instruction kinds and one-hot op helper for the ID stage
package id_stage_pipe_pkg;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // SPECIAL func codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // sa/rs qualification value
  localparam logic [4:0] FIELD_ZERO = 5'd0;

  localparam int ALUOP_N = 21;

  localparam logic READ_EN   = 1'b1;
  localparam logic READ_DIS  = 1'b0;
  localparam logic WRITE_EN  = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  // Order matches the one-hot op MSB-first: K_ADD -> bit 20 ... K_JAL -> bit 0.
  typedef enum logic [4:0] {
    K_NOP, K_ADD, K_ADDU, K_SUB, K_SUBU, K_SLT, K_SLTU, K_AND, K_OR, K_XOR, K_NOR,
    K_SLL, K_SRL, K_SRA, K_LUI, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE, K_JR, K_JAL
  } inst_kind_e;

  // R-type ALU ops and jr need sa==0, shifts need rs==0, lui needs rs==0.
  function automatic inst_kind_e decode_kind(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] sa;
    inst_kind_e k;
    op = inst[31:26];
    fn = inst[5:0];
    rs = inst[25:21];
    sa = inst[10:6];
    k  = K_NOP;
    case (op)
      OP_SPECIAL: begin
        if (sa == FIELD_ZERO) begin
          case (fn)
            FN_ADD:  k = K_ADD;
            FN_ADDU: k = K_ADDU;
            FN_SUB:  k = K_SUB;
            FN_SUBU: k = K_SUBU;
            FN_SLT:  k = K_SLT;
            FN_SLTU: k = K_SLTU;
            FN_AND:  k = K_AND;
            FN_OR:   k = K_OR;
            FN_XOR:  k = K_XOR;
            FN_NOR:  k = K_NOR;
            FN_JR:   k = K_JR;
            default: ;
          endcase
        end
        if (rs == FIELD_ZERO) begin
          case (fn)
            FN_SLL:  k = K_SLL;
            FN_SRL:  k = K_SRL;
            FN_SRA:  k = K_SRA;
            default: ;
          endcase
        end
      end
      OP_LUI:   if (rs == FIELD_ZERO) k = K_LUI;
      OP_ADDIU: k = K_ADDIU;
      OP_LW:    k = K_LW;
      OP_SW:    k = K_SW;
      OP_BEQ:   k = K_BEQ;
      OP_BNE:   k = K_BNE;
      OP_JAL:   k = K_JAL;
      default:  k = K_NOP;
    endcase
    return k;
  endfunction

  // K_NOP shifts the single 1 out of the word, giving an all-zero op.
  function automatic logic [ALUOP_N-1:0] kind_to_aluop(input inst_kind_e k);
    logic [ALUOP_N-1:0] one;
    one = {{(ALUOP_N-1){1'b0}}, 1'b1};
    return one << (ALUOP_N - int'(k));
  endfunction

endpackage

// File: rtl/id_fwd_unit.sv
// rtl/id_fwd_unit.sv - per-operand forwarding mux and hazard compare; network built only with ID_FWD_EN
module id_fwd_unit
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              re_i,
  input  logic [REG_AW-1:0] raddr_i,
  input  logic [DATA_W-1:0] rf_rdata_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hazard_o
);

  logic live;
  logic ex_hit;
  logic mem_hit;

  // $0 is hard-wired, so a write to it never matches a reader
  assign live    = (re_i == READ_EN) && (raddr_i != '0);
  assign ex_hit  = live && ex_wreg_i && (ex_wd_i == raddr_i);
  assign mem_hit = live && mem_wreg_i && (mem_wd_i == raddr_i);

`ifdef ID_FWD_EN
  // EX holds the younger result so it beats MEM; a load in EX has no data yet
  always_comb begin
    hazard_o = ex_hit && ex_is_load_i;
    if (ex_hit) begin
      rdata_o = ex_wdata_i;
    end else if (mem_hit) begin
      rdata_o = mem_wdata_i;
    end else begin
      rdata_o = rf_rdata_i;
    end
  end
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};

  // without bypass paths any in-flight write to the operand must drain first
  always_comb begin
    hazard_o = ex_hit || mem_hit;
    rdata_o  = rf_rdata_i;
  end
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered MIPS decode stage with forwarding, load-use stall, delay slot; option ID_FWD_EN
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  pc_i,
  output logic [REG_AW-1:0]  rf_raddr1_o,
  output logic [REG_AW-1:0]  rf_raddr2_o,
  input  logic [DATA_W-1:0]  rf_rdata1_i,
  input  logic [DATA_W-1:0]  rf_rdata2_i,
  input  logic               ex_wreg_i,
  input  logic [REG_AW-1:0]  ex_wd_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wreg_i,
  input  logic [REG_AW-1:0]  mem_wd_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic               ex_ready_i,
  output logic               id_valid_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [DATA_W-1:0]  reg1_o,
  output logic [DATA_W-1:0]  reg2_o,
  output logic [REG_AW-1:0]  wd_o,
  output logic               wreg_o,
  output logic               is_load_o,
  output logic [DATA_W-1:0]  link_addr_o,
  output logic               is_in_delayslot_o,
  output logic [31:0]        inst_o,
  output logic               branch_flag_o,
  output logic [DATA_W-1:0]  branch_target_o
);

  localparam logic [REG_AW-1:0] LINK_REG = '1;

  inst_kind_e        kind;
  logic              re1, re2, wreg_dec;
  logic [REG_AW-1:0] rs, rt, rd, wd_dec;
  logic [DATA_W-1:0] imm, fwd1, fwd2, op1, op2, pc4, br_off, target;
  logic              haz1, haz2, stall, slot_free, fire, taken;

  logic               id_valid_q, id_valid_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DATA_W-1:0]  reg1_q, reg1_d, reg2_q, reg2_d, link_addr_q, link_addr_d;
  logic [REG_AW-1:0]  wd_q, wd_d;
  logic               wreg_q, wreg_d, is_load_q, is_load_d;
  logic               in_ds_q, in_ds_d, ds_flag_q, ds_flag_d;
  logic [31:0]        inst_q, inst_d;

  assign rs = REG_AW'(inst_i[25:21]);
  assign rt = REG_AW'(inst_i[20:16]);
  assign rd = REG_AW'(inst_i[15:11]);
  assign rf_raddr1_o = rs;
  assign rf_raddr2_o = rt;

  // classify the word, then derive read/write enables, destination and immediate
  always_comb begin
    kind     = decode_kind(inst_i);
    re1      = READ_DIS;
    re2      = READ_DIS;
    wreg_dec = WRITE_DIS;
    wd_dec   = rd;
    imm      = {{(DATA_W-5){1'b0}}, inst_i[10:6]};
    case (kind)
      K_ADD, K_ADDU, K_SUB, K_SUBU, K_SLT, K_SLTU, K_AND, K_OR, K_XOR, K_NOR: begin
        re1      = READ_EN;
        re2      = READ_EN;
        wreg_dec = WRITE_EN;
      end
      K_SLL, K_SRL, K_SRA: begin
        re2      = READ_EN;
        wreg_dec = WRITE_EN;
      end
      K_LUI: begin
        wreg_dec = WRITE_EN;
        wd_dec   = rt;
        imm      = {inst_i[15:0], {(DATA_W-16){1'b0}}};
      end
      K_ADDIU, K_LW: begin
        re1      = READ_EN;
        wreg_dec = WRITE_EN;
        wd_dec   = rt;
        imm      = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
      end
      K_SW: begin
        re1 = READ_EN;
        re2 = READ_EN;
        imm = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
      end
      K_BEQ, K_BNE: begin
        re1 = READ_EN;
        re2 = READ_EN;
      end
      K_JR: re1 = READ_EN;
      K_JAL: begin
        wreg_dec = WRITE_EN;
        wd_dec   = LINK_REG;
      end
      default: ;
    endcase
  end

  id_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .re_i(re1), .raddr_i(rs), .rf_rdata_i(rf_rdata1_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .rdata_o(fwd1), .hazard_o(haz1)
  );

  id_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .re_i(re2), .raddr_i(rt), .rf_rdata_i(rf_rdata2_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .rdata_o(fwd2), .hazard_o(haz2)
  );

  // operands fall back to the immediate when not read; branches compare forwarded values
  always_comb begin
    op1    = re1 ? fwd1 : imm;
    op2    = re2 ? fwd2 : imm;
    pc4    = pc_i + DATA_W'(4);
    br_off = {{(DATA_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
    taken  = 1'b0;
    target = '0;
    case (kind)
      K_BEQ: begin
        taken  = (op1 == op2);
        target = pc4 + br_off;
      end
      K_BNE: begin
        taken  = (op1 != op2);
        target = pc4 + br_off;
      end
      K_JR: begin
        taken  = 1'b1;
        target = op1;
      end
      K_JAL: begin
        taken  = 1'b1;
        target = {pc4[DATA_W-1:28], inst_i[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  assign stall           = if_valid_i && (haz1 || haz2);
  assign slot_free       = !id_valid_q || ex_ready_i;
  assign if_ready_o      = slot_free && !stall && !flush_i;
  assign fire            = if_valid_i && if_ready_o;
  assign branch_flag_o   = fire && taken;
  assign branch_target_o = branch_flag_o ? target : '0;

  // ID/EX register: flush wins, then load on fire, then bubble when the slot drains
  always_comb begin
    id_valid_d  = id_valid_q;
    aluop_d     = aluop_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    is_load_d   = is_load_q;
    link_addr_d = link_addr_q;
    in_ds_d     = in_ds_q;
    inst_d      = inst_q;
    ds_flag_d   = ds_flag_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
      ds_flag_d  = 1'b0;
    end else if (fire) begin
      id_valid_d  = 1'b1;
      aluop_d     = ALUOP_W'(kind_to_aluop(kind));
      reg1_d      = op1;
      reg2_d      = op2;
      wd_d        = wd_dec;
      wreg_d      = wreg_dec;
      is_load_d   = (kind == K_LW);
      link_addr_d = (kind == K_JAL) ? pc_i + DATA_W'(8) : '0;
      in_ds_d     = ds_flag_q;
      inst_d      = inst_i;
      ds_flag_d   = branch_flag_o;
    end else if (slot_free) begin
      id_valid_d = 1'b0;
    end
  end

  // state update with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q  <= 1'b0;
      aluop_q     <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      is_load_q   <= 1'b0;
      link_addr_q <= '0;
      in_ds_q     <= 1'b0;
      inst_q      <= '0;
      ds_flag_q   <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      aluop_q     <= aluop_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      is_load_q   <= is_load_d;
      link_addr_q <= link_addr_d;
      in_ds_q     <= in_ds_d;
      inst_q      <= inst_d;
      ds_flag_q   <= ds_flag_d;
    end
  end

  assign id_valid_o        = id_valid_q;
  assign aluop_o           = aluop_q;
  assign reg1_o            = reg1_q;
  assign reg2_o            = reg2_q;
  assign wd_o              = wd_q;
  assign wreg_o            = wreg_q;
  assign is_load_o         = is_load_q;
  assign link_addr_o       = link_addr_q;
  assign is_in_delayslot_o = in_ds_q;
  assign inst_o            = inst_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - randomized and directed bench for id_stage_pipe against a table-driven model
module tb_id_stage_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush_i, if_valid_i, if_ready_o;
  logic [31:0] inst_i, inst_o;
  logic [DW-1:0] pc_i, rf_rdata1_i, rf_rdata2_i, ex_wdata_i, mem_wdata_i;
  logic [AW-1:0] rf_raddr1_o, rf_raddr2_o, ex_wd_i, mem_wd_i, wd_o;
  logic ex_wreg_i, ex_is_load_i, mem_wreg_i, ex_ready_i;
  logic id_valid_o, wreg_o, is_load_o, is_in_delayslot_o, branch_flag_o;
  logic [OW-1:0] aluop_o;
  logic [DW-1:0] reg1_o, reg2_o, link_addr_o, branch_target_o;

  id_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .aluop_o(aluop_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o),
    .link_addr_o(link_addr_o), .is_in_delayslot_o(is_in_delayslot_o), .inst_o(inst_o),
    .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o)
  );

  // instruction table: dst 0=rd 1=rt 2=link; immk 0=sa 1=sext 2=lui; br 0=none 1=beq 2=bne 3=jr 4=jal
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          bitpos;
    bit          rd_rs;
    bit          rd_rt;
    bit          wr;
    int          dst;
    int          immk;
    int          br;
  } ent_t;

  ent_t tbl[21];
  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic        m_valid, m_wreg, m_isload, m_ds, m_flag;
  logic [20:0] m_aluop;
  logic [31:0] m_reg1, m_reg2, m_link, m_inst;
  logic [4:0]  m_wd;

  logic        last_ready, last_bf;
  logic [31:0] last_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] mask, input logic [31:0] match, input int b,
                              input bit r1, input bit r2, input bit w, input int d, input int ik,
                              input int br);
    ent_t e;
    e.mask = mask; e.match = match; e.bitpos = b; e.rd_rs = r1; e.rd_rt = r2;
    e.wr = w; e.dst = d; e.immk = ik; e.br = br;
    return e;
  endfunction

  task automatic init_tbl();
    logic [31:0] mr, ms, mo;
    mr = 32'hFC00_07FF;
    ms = 32'hFFE0_003F;
    mo = 32'hFC00_0000;
    tbl[0]  = mk(mr, 32'h0000_0020, 20, 1, 1, 1, 0, 0, 0);
    tbl[1]  = mk(mr, 32'h0000_0021, 19, 1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(mr, 32'h0000_0022, 18, 1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(mr, 32'h0000_0023, 17, 1, 1, 1, 0, 0, 0);
    tbl[4]  = mk(mr, 32'h0000_002A, 16, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(mr, 32'h0000_002B, 15, 1, 1, 1, 0, 0, 0);
    tbl[6]  = mk(mr, 32'h0000_0024, 14, 1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(mr, 32'h0000_0025, 13, 1, 1, 1, 0, 0, 0);
    tbl[8]  = mk(mr, 32'h0000_0026, 12, 1, 1, 1, 0, 0, 0);
    tbl[9]  = mk(mr, 32'h0000_0027, 11, 1, 1, 1, 0, 0, 0);
    tbl[10] = mk(ms, 32'h0000_0000, 10, 0, 1, 1, 0, 0, 0);
    tbl[11] = mk(ms, 32'h0000_0002,  9, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk(ms, 32'h0000_0003,  8, 0, 1, 1, 0, 0, 0);
    tbl[13] = mk(32'hFFE0_0000, 32'h3C00_0000, 7, 0, 0, 1, 1, 2, 0);
    tbl[14] = mk(mo, 32'h2400_0000, 6, 1, 0, 1, 1, 1, 0);
    tbl[15] = mk(mo, 32'h8C00_0000, 5, 1, 0, 1, 1, 1, 0);
    tbl[16] = mk(mo, 32'hAC00_0000, 4, 1, 1, 0, 0, 1, 0);
    tbl[17] = mk(mo, 32'h1000_0000, 3, 1, 1, 0, 0, 0, 1);
    tbl[18] = mk(mo, 32'h1400_0000, 2, 1, 1, 0, 0, 0, 2);
    tbl[19] = mk(mr, 32'h0000_0008, 1, 1, 0, 0, 0, 0, 3);
    tbl[20] = mk(mo, 32'h0C00_0000, 0, 0, 0, 1, 2, 0, 4);
  endtask

  function automatic void res(input logic [4:0] a, input bit en, input logic [31:0] rf,
                              output logic [31:0] d, output bit hz);
    bit exm, memm;
    exm  = en && (a != 5'd0) && ex_wreg_i && (ex_wd_i == a);
    memm = en && (a != 5'd0) && mem_wreg_i && (mem_wd_i == a);
`ifdef ID_FWD_EN
    hz = exm && ex_is_load_i;
    d  = exm ? ex_wdata_i : (memm ? mem_wdata_i : rf);
`else
    hz = exm || memm;
    d  = rf;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_aluop = '0; m_reg1 = '0; m_reg2 = '0; m_wd = '0; m_wreg = 0;
    m_isload = 0; m_link = '0; m_ds = 0; m_inst = '0; m_flag = 0;
  endtask

  task automatic check_regs(input string t);
    chk({t, ".valid"}, 32'(id_valid_o), 32'(m_valid));
    chk({t, ".aluop"}, 32'(aluop_o), 32'(m_aluop));
    chk({t, ".reg1"}, reg1_o, m_reg1);
    chk({t, ".reg2"}, reg2_o, m_reg2);
    chk({t, ".wd"}, 32'(wd_o), 32'(m_wd));
    chk({t, ".wreg"}, 32'(wreg_o), 32'(m_wreg));
    chk({t, ".isload"}, 32'(is_load_o), 32'(m_isload));
    chk({t, ".link"}, link_addr_o, m_link);
    chk({t, ".ds"}, 32'(is_in_delayslot_o), 32'(m_ds));
    chk({t, ".inst"}, inst_o, m_inst);
  endtask

  // called at posedge+1 with inputs already driven; returns at the following posedge+1
  task automatic cycle(input string t);
    ent_t e;
    bit hit, h1, h2, stall, sf, rdy, fire, taken, bf;
    logic [31:0] imm, d1, d2, o1, o2, pc4, tgt, etgt;
    logic [20:0] a;
    logic [4:0] rs, rt, rd, wd;
    hit = 0;
    e = mk(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    for (int i = 0; i < 21; i++)
      if ((inst_i & tbl[i].mask) == tbl[i].match) begin
        e = tbl[i];
        hit = 1;
      end
    rs = inst_i[25:21]; rt = inst_i[20:16]; rd = inst_i[15:11];
    case (e.immk)
      1:       imm = {{16{inst_i[15]}}, inst_i[15:0]};
      2:       imm = {inst_i[15:0], 16'h0};
      default: imm = {27'h0, inst_i[10:6]};
    endcase
    res(rs, e.rd_rs, rf_rdata1_i, d1, h1);
    res(rt, e.rd_rt, rf_rdata2_i, d2, h2);
    o1 = e.rd_rs ? d1 : imm;
    o2 = e.rd_rt ? d2 : imm;
    stall = if_valid_i && (h1 || h2);
    sf    = !m_valid || ex_ready_i;
    rdy   = sf && !stall && !flush_i;
    fire  = if_valid_i && rdy;
    pc4   = pc_i + 32'd4;
    taken = 0;
    tgt   = 32'h0;
    case (e.br)
      1: begin taken = (o1 == o2); tgt = pc4 + ({{16{inst_i[15]}}, inst_i[15:0]} << 2); end
      2: begin taken = (o1 != o2); tgt = pc4 + ({{16{inst_i[15]}}, inst_i[15:0]} << 2); end
      3: begin taken = 1; tgt = o1; end
      4: begin taken = 1; tgt = {pc4[31:28], inst_i[25:0], 2'b00}; end
      default: ;
    endcase
    bf   = fire && taken;
    etgt = bf ? tgt : 32'h0;
    chk({t, ".ready"}, 32'(if_ready_o), 32'(rdy));
    chk({t, ".bflag"}, 32'(branch_flag_o), 32'(bf));
    chk({t, ".btgt"}, branch_target_o, etgt);
    chk({t, ".ra1"}, 32'(rf_raddr1_o), 32'(rs));
    chk({t, ".ra2"}, 32'(rf_raddr2_o), 32'(rt));
    last_ready = if_ready_o;
    last_bf    = branch_flag_o;
    last_tgt   = branch_target_o;
    @(posedge clk);
    #1;
    if (flush_i) begin
      m_valid = 0;
      m_flag  = 0;
    end else if (fire) begin
      a = '0;
      if (hit) a[e.bitpos] = 1'b1;
      wd = (e.dst == 1) ? rt : ((e.dst == 2) ? 5'd31 : rd);
      m_valid = 1; m_aluop = a; m_reg1 = o1; m_reg2 = o2; m_wd = wd;
      m_wreg = hit && e.wr; m_isload = hit && (e.bitpos == 5);
      m_link = (hit && e.br == 4) ? pc_i + 32'd8 : 32'h0;
      m_ds = m_flag; m_inst = inst_i; m_flag = bf;
    end else if (sf) begin
      m_valid = 0;
    end
    check_regs(t);
  endtask

  task automatic rnd_inputs();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 22);
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    r[15:11] = 5'($urandom_range(0, 3));
    if (k < 21) inst_i = (r & ~tbl[k].mask) | tbl[k].match;
    else        inst_i = r;
    pc_i         = $urandom & 32'hFFFF_FFFC;
    rf_rdata1_i  = $urandom;
    rf_rdata2_i  = ($urandom_range(0, 2) == 0) ? rf_rdata1_i : $urandom;
    if_valid_i   = ($urandom_range(0, 3) != 0);
    ex_ready_i   = ($urandom_range(0, 3) != 0);
    flush_i      = ($urandom_range(0, 19) == 0);
    ex_wreg_i    = 1'($urandom_range(0, 1));
    ex_wd_i      = 5'($urandom_range(0, 3));
    ex_wdata_i   = $urandom;
    ex_is_load_i = 1'($urandom_range(0, 1));
    mem_wreg_i   = 1'($urandom_range(0, 1));
    mem_wd_i     = 5'($urandom_range(0, 3));
    mem_wdata_i  = $urandom;
  endtask

  function automatic logic [31:0] addu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'b0, s, t, d, 5'b0, 6'b100001};
  endfunction

  initial begin
    init_tbl();
    model_reset();
    rst = 0; flush_i = 0; if_valid_i = 0; inst_i = '0; pc_i = '0;
    rf_rdata1_i = '0; rf_rdata2_i = '0; ex_wreg_i = 0; ex_wd_i = '0; ex_wdata_i = '0;
    ex_is_load_i = 0; mem_wreg_i = 0; mem_wd_i = '0; mem_wdata_i = '0; ex_ready_i = 1;
    #12;
    check_regs("rst");
    rst = 1;
    @(posedge clk);
    #1;

    // addu $3,$1,$2
    if_valid_i = 1; inst_i = addu(5'd3, 5'd1, 5'd2); rf_rdata1_i = 5; rf_rdata2_i = 7;
    cycle("addu");
    chk("addu.bit", 32'(aluop_o[19]), 32'd1);
    chk("addu.r1", reg1_o, 32'd5);
    chk("addu.r2", reg2_o, 32'd7);
    chk("addu.wd", 32'(wd_o), 32'd3);

    // load-use: lw $4 in EX, addu $5,$4,$4 in ID
    inst_i = addu(5'd5, 5'd4, 5'd4); rf_rdata1_i = 32'h11; rf_rdata2_i = 32'h11;
    ex_wreg_i = 1; ex_wd_i = 5'd4; ex_is_load_i = 1;
    cycle("lu0");
    chk("lu.stall", 32'(last_ready), 32'd0);
    chk("lu.bubble", 32'(id_valid_o), 32'd0);
    ex_wreg_i = 0; ex_is_load_i = 0; mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'h55;
    cycle("lu1");
`ifdef ID_FWD_EN
    chk("lu.fwd1", reg1_o, 32'h55);
    chk("lu.fwd2", reg2_o, 32'h55);
`else
    chk("lu.memstall", 32'(last_ready), 32'd0);
`endif

    // EX vs MEM priority, then $0 never forwarded
    inst_i = addu(5'd6, 5'd1, 5'd2); rf_rdata1_i = 32'h1111; rf_rdata2_i = 32'h2222;
    ex_wreg_i = 1; ex_wd_i = 5'd2; ex_wdata_i = 32'hAA; mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'hBB;
    cycle("prio");
`ifdef ID_FWD_EN
    chk("prio.r2", reg2_o, 32'hAA);
    chk("prio.r1", reg1_o, 32'h1111);
`else
    chk("prio.stall", 32'(last_ready), 32'd0);
`endif
    inst_i = addu(5'd6, 5'd0, 5'd0); rf_rdata1_i = 0; rf_rdata2_i = 0; ex_wd_i = 5'd0; mem_wd_i = 5'd0;
    cycle("zero");
    chk("zero.r1", reg1_o, 32'd0);
    chk("zero.r2", reg2_o, 32'd0);
    chk("zero.v", 32'(id_valid_o), 32'd1);

    // beq taken and its delay slot
    ex_wreg_i = 0; mem_wreg_i = 0;
    inst_i = {6'b000100, 5'd1, 5'd2, 16'h0003}; pc_i = 32'h100; rf_rdata1_i = 9; rf_rdata2_i = 9;
    cycle("beq");
    chk("beq.flag", 32'(last_bf), 32'd1);
    chk("beq.tgt", last_tgt, 32'h110);
    inst_i = addu(5'd7, 5'd1, 5'd2); pc_i = 32'h104;
    cycle("slot");
    chk("slot.ds", 32'(is_in_delayslot_o), 32'd1);
    pc_i = 32'h108;
    cycle("after");
    chk("after.ds", 32'(is_in_delayslot_o), 32'd0);

    // jal, then hold under back-pressure
    inst_i = {6'b000011, 26'h10}; pc_i = 32'h0040_0000;
    cycle("jal");
    chk("jal.tgt", last_tgt, 32'h40);
    chk("jal.wd", 32'(wd_o), 32'd31);
    chk("jal.link", link_addr_o, 32'h0040_0008);
    ex_ready_i = 0; inst_i = addu(5'd8, 5'd1, 5'd2); pc_i = 32'h0040_0004;
    cycle("hold0");
    cycle("hold1");
    chk("hold.ready", 32'(last_ready), 32'd0);
    chk("hold.link", link_addr_o, 32'h0040_0008);
    chk("hold.wd", 32'(wd_o), 32'd31);

    // flush kills the held entry and the pending delay slot
    flush_i = 1;
    cycle("flush");
    chk("flush.v", 32'(id_valid_o), 32'd0);
    flush_i = 0; ex_ready_i = 1;
    cycle("postflush");
    chk("postflush.v", 32'(id_valid_o), 32'd1);
    chk("postflush.ds", 32'(is_in_delayslot_o), 32'd0);

    // non-load EX match: forwarded, or stalled until it clears
    inst_i = addu(5'd7, 5'd1, 5'd0); rf_rdata1_i = 32'h33; rf_rdata2_i = 0;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_is_load_i = 0; ex_wdata_i = 32'h77;
`ifdef ID_FWD_EN
    cycle("exfwd");
    chk("exfwd.r1", reg1_o, 32'h77);
`else
    cycle("exst0");
    chk("exst0.ready", 32'(last_ready), 32'd0);
    cycle("exst1");
    chk("exst1.ready", 32'(last_ready), 32'd0);
    ex_wreg_i = 0;
    cycle("exgo");
    chk("exgo.ready", 32'(last_ready), 32'd1);
    chk("exgo.r1", reg1_o, 32'h33);
`endif

    // reset in the middle of a stall with a held entry
    ex_ready_i = 0; ex_wreg_i = 1; ex_wd_i = 5'd1; ex_is_load_i = 1;
    cycle("prerst");
    rst = 0;
    #1;
    model_reset();
    check_regs("rstmid");
    if_valid_i = 0; ex_wreg_i = 0; ex_is_load_i = 0; ex_ready_i = 1;
    rst = 1;
    cycle("postrst");

    repeat (400) begin
      rnd_inputs();
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
